uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares a single serial transmit line between `NREQ` byte requesters. It arbitrates round-robin, frames each granted byte as 8N1 (start bit, 8 data bits LSB first, stop bit) and times every bit with an internal baud down-counter. It sits between the on-chip message sources and the board's `data` serial pin and replaces free-running pattern generators on that pin.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `BAUD_DIV`, 16'd1302: baud counter reload value. One bit time is `BAUD_DIV+1` clk cycles.

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input `NREQ`: requester i has a byte pending.
- `req_data` input `8*NREQ`: byte of requester i in bits `[8i+7:8i]`. It must be held stable while `req_valid[i]` is high.
- `req_ready` output `NREQ`: one-hot accept strobe. The byte is taken on the cycle `req_valid[i] && req_ready[i]`.
- `tx` output 1: serial line, idle high.
- `busy` output 1: a frame is in progress.
- `grant_id` output `$clog2(NREQ)`: index of the last granted requester.
- `frame_done` output 1: one-cycle pulse when a frame's stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, STOP. Also registered: `baud_cnt[15:0]`, `bit_cnt[2:0]`, `shift[7:0]`, `last_grant`.
- **IDLE**
  - `tx`=1 and `busy`=0.
  - If any `req_valid` bit is set, search from `last_grant+1` upward, with modulo-`NREQ` wrap.
  - The first set index i wins. `req_ready[i]`=1 combinationally in this cycle, and only in this cycle.
  - On that edge: `shift`<=byte i, `grant_id`<=i, `last_grant`<=i, `baud_cnt`<=`BAUD_DIV`, then go to START.
- **START**: `tx`=0. When `baud_cnt`==0, reload `baud_cnt`, set `bit_cnt`<=0 and go to DATA. Otherwise decrement `baud_cnt`.
- **DATA**
  - `tx`=`shift[0]`.
  - When `baud_cnt`==0: reload `baud_cnt` and shift `shift` right by one.
    - If `bit_cnt`==7, go to STOP.
    - Otherwise increment `bit_cnt`.
- **STOP**: `tx`=1. When `baud_cnt`==0, go to IDLE and set `frame_done`<=1 for the next cycle.
- `req_ready` is 0 in every state except IDLE. Requests that arrive mid-frame wait.
- A requester may drop `req_valid` before it is granted. No byte is taken and there is no penalty.
- `busy`=1 in START, DATA and STOP.
- `tx`, `busy` and `frame_done` are registered (glitch-free). `req_ready` is combinational from state and `req_valid`.

## Timing
- Reset values: `tx`=1, `busy`=0, `req_ready`=0, `frame_done`=0, `grant_id`=0, state=IDLE, `baud_cnt`=`BAUD_DIV`, `last_grant`=`NREQ-1` (requester 0 has top priority after reset).
- Handshake to start bit: `tx` falls on the first clock after the accept cycle.
- Frame length: exactly `10*(BAUD_DIV+1)` cycles with `tx` driven by the frame. The default is 13030 cycles.
- `frame_done` is high on the single cycle state=IDLE after STOP.
- Back-to-back frames: the earliest next start bit follows the previous stop bit after exactly 1 IDLE cycle (the arbitration cycle).
- Round-robin: with all requesters continuously valid, grant order is 0,1,…,NREQ-1,0.
- Wrap-around: when `last_grant`=`NREQ-1`, the search starts at 0.
- Reset mid-frame:
  - `tx` goes to 1 and `busy` to 0 immediately (asynchronous).
  - The partial frame is abandoned and `frame_done` is not pulsed.
  - Arbitration restarts with requester 0 having top priority.
- `req_valid` asserted in the same cycle that STOP ends: it is not seen until the IDLE cycle, where it is accepted.

## Test plan
All scenarios use `NREQ`=4 and `BAUD_DIV`=3 (4 cycles per bit).

1. **Reset:** assert `rst` for 3 cycles, then release with no requests. Required: `tx`=1, `busy`=0, `req_ready`=0 and `frame_done`=0, held for 50 cycles.
2. **Single byte:** `req_valid`=4'b0001 with byte 0xA5.
   - `req_ready`=4'b0001 for exactly one cycle.
   - `tx` then shows 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit (40 cycles).
   - `frame_done` pulses once and `grant_id`=0.
3. **All four valid continuously:** bytes 0x10, 0x21, 0x32, 0x43.
   - Grants occur in order 0,1,2,3,0.
   - There is exactly 1 idle cycle between each stop bit and the next start bit.
   - Decoded `tx` bytes match the granted requester.
4. **Fairness:** only req 2 valid; it is granted. During its frame, assert req 1 and req 3. Required: req 3 is granted before req 1, and `grant_id` reads 2, then 3, then 1.
5. **Reset mid-frame:** assert `rst` during DATA bit 4. Required:
   - `tx`=1 asynchronously, with no `frame_done`.
   - After release, with req 0 and req 3 valid, req 0 is granted first.
6. **Late arrival and withdrawal:**
   - Req 1 is raised mid-frame and dropped before STOP ends. Required: req 1 is never granted and `tx` stays idle.
   - Req 1 is asserted on the last STOP cycle. Required: it is accepted in the following IDLE cycle.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Bundle of the requester handshake and the serial-side status signals of
// uart_tx_arbiter. The arbiter binds to the slave modport, the message
// sources (or a bench) to the master modport.
//
// Parameters:
//   NREQ        number of byte requesters (2..8); must match the arbiter
//
// Signals:
//   req_valid   [NREQ]    requester i has a byte pending
//   req_data    [8*NREQ]  byte of requester i in bits [8i+7:8i]
//   req_ready   [NREQ]    one-hot accept strobe from the arbiter
//   tx          1         serial line, idle high
//   busy        1         a frame is in progress
//   grant_id    [clog2]   index of the last granted requester
//   frame_done  1         one-cycle pulse after a stop bit completes
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
   parameter int NREQ = 4
);

   localparam int GW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              tx;
   logic              busy;
   logic [GW-1:0]     grant_id;
   logic              frame_done;

   // Requester side: offers bytes, observes the accept strobe and line status
   modport master (
      output req_valid,
      output req_data,
      input  req_ready,
      input  tx,
      input  busy,
      input  grant_id,
      input  frame_done
   );

   // Arbiter side: consumes requests, drives the serial line and status
   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready,
      output tx,
      output busy,
      output grant_id,
      output frame_done
   );

endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one serial transmit pin between NREQ byte requesters. Requests are
// served round-robin; each granted byte is sent as an 8N1 frame (start bit,
// eight data bits LSB first, stop bit). Every bit lasts BAUD_DIV+1 clocks,
// timed by a reloading down-counter.
//
// Parameters:
//   NREQ        number of requesters (2..8)
//   BAUD_DIV    baud counter reload value; one bit = BAUD_DIV+1 clocks
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   bus         uart_tx_arbiter_if.slave:
//                  req_valid/req_data in, req_ready (combinational) out,
//                  tx/busy/frame_done/grant_id (registered) out
//
// Frame timing: the accept cycle is the single IDLE cycle in which
// req_ready is high; tx falls on the next clock and the frame then occupies
// exactly 10*(BAUD_DIV+1) clocks, followed by at least one IDLE cycle.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int          NREQ     = 4,
   parameter logic [15:0] BAUD_DIV = 16'd1302
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int GW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   baud_cnt_q, baud_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [GW-1:0] last_grant_q, last_grant_d;
   logic [GW-1:0] grant_id_q, grant_id_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          frame_done_q, frame_done_d;

   logic          win_found;
   logic [GW-1:0] win_idx;
   logic [7:0]    win_byte;
   logic          accept;

   // Round-robin search: start one past the last winner and walk upward with
   // modulo-NREQ wrap, so the requester just served has the lowest priority.
   // After reset last_grant is NREQ-1, which makes requester 0 the first
   // candidate.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!win_found && bus.req_valid[GW'((int'(last_grant_q) + k) % NREQ)]) begin
            win_found = 1'b1;
            win_idx   = GW'((int'(last_grant_q) + k) % NREQ);
         end
      end
   end

   // Pick the winner's byte out of the packed data bus. A compare loop keeps
   // the select free of variable-width part-select arithmetic.
   always_comb begin
      win_byte = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (GW'(i) == win_idx) begin
            win_byte = bus.req_data[8*i +: 8];
         end
      end
   end

   // A byte is taken only in IDLE. The accept strobe is combinational so the
   // requester sees it in the same cycle it is offered; it is forced low
   // while reset is held so the strobe reads 0 during reset.
   assign accept = (state_q == IDLE) && win_found && !rst;

   always_comb begin
      bus.req_ready = '0;
      if (accept) begin
         bus.req_ready[win_idx] = 1'b1;
      end
   end

   // Frame sequencer next-state logic. Each of START, DATA and STOP holds for
   // BAUD_DIV+1 clocks: the counter is loaded with BAUD_DIV on entry and the
   // state advances in the cycle where it reads zero. DATA repeats for eight
   // bits, shifting the byte right so bit 0 is always the one on the line.
   // The line outputs are derived from the next state so that tx, busy and
   // frame_done come straight from flops and change together with the state.
   always_comb begin
      state_d      = state_q;
      baud_cnt_d   = baud_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      frame_done_d = 1'b0;
      tx_d         = 1'b1;
      busy_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d      = win_byte;
               grant_id_d   = win_idx;
               last_grant_d = win_idx;
               baud_cnt_d   = BAUD_DIV;
               state_d      = START;
            end
         end

         START: begin
            if (baud_cnt_q == 16'd0) begin
               baud_cnt_d = BAUD_DIV;
               bit_cnt_d  = 3'd0;
               state_d    = DATA;
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end

         DATA: begin
            if (baud_cnt_q == 16'd0) begin
               baud_cnt_d = BAUD_DIV;
               shift_d    = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end

         STOP: begin
            if (baud_cnt_q == 16'd0) begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      case (state_d)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
         START: begin
            tx_d   = 1'b0;
            busy_d = 1'b1;
         end
         DATA: begin
            tx_d   = shift_d[0];
            busy_d = 1'b1;
         end
         STOP: begin
            tx_d   = 1'b1;
            busy_d = 1'b1;
         end
         default: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
      endcase
   end

   // State and output registers. Reset is asynchronous so an abandoned frame
   // releases the line (tx high, busy low) at once; no frame_done is produced
   // for it and arbitration restarts with requester 0 first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         baud_cnt_q   <= BAUD_DIV;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'd0;
         last_grant_q <= GW'(NREQ - 1);
         grant_id_q   <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         baud_cnt_q   <= baud_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.tx         = tx_q;
   assign bus.busy       = busy_q;
   assign bus.grant_id   = grant_id_q;
   assign bus.frame_done = frame_done_q;

endmodule
